// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision adder.
// Operands are held in registers for LAT cycles before the sum is captured.
module fpu_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 2,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_data,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  generate
    if (LAT < 1) begin : g_lat_chk
      $error("fpu_add_arbiter: LAT must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   op_a_q, op_a_d;
  logic [31:0]   op_b_q, op_b_d;
  logic [31:0]   res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] grant_q, grant_d;
  logic          busy_q, busy_d;

  logic [GW-1:0] win;
  logic [GW-1:0] k;
  logic          win_vld;
  logic [31:0]   fpu_f3;

  FPU u_fpu (
    .F1 (op_a_q),
    .F2 (op_b_q),
    .F3 (fpu_f3)
  );

  // Scan last+1, last+2, ... so the previous owner goes to the back.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    k       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = GW'((int'(last_q) + i) % N_REQ);
      if (!win_vld && req_valid[k]) begin
        win_vld = 1'b1;
        win     = k;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          req_ready[win] = 1'b1;
          op_a_d  = req_a[int'(win)*32 +: 32];
          op_b_d  = req_b[int'(win)*32 +: 32];
          grant_d = win;
          cnt_d   = CW'(LAT - 1);
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          res_d   = fpu_f3;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          last_d  = grant_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) req_ready = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      last_q  <= GW'(N_REQ - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
  end

  assign rsp_data = res_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

module FPU (
  input  logic [31:0] F1,
  input  logic [31:0] F2,
  output logic [31:0] F3
);

  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [31:0] big, sml;
  logic        sub, found, rnd;
  logic [7:0]  ex, ey, d, dd, lim, shamt;
  logic [23:0] mx, my;
  logic [26:0] ax, ay, yy, n;
  logic [53:0] sh;
  logic [27:0] s;
  logic [4:0]  lz;
  logic [9:0]  e;
  logic [24:0] m;
  logic [22:0] frac;
  logic [31:0] norm;

  always_comb begin
    nan_a  = (&F1[30:23]) && (|F1[22:0]);
    nan_b  = (&F2[30:23]) && (|F2[22:0]);
    inf_a  = (&F1[30:23]) && !(|F1[22:0]);
    inf_b  = (&F2[30:23]) && !(|F2[22:0]);
    zero_a = F1[30:0] == 31'd0;
    zero_b = F2[30:0] == 31'd0;

    if (F1[30:0] >= F2[30:0]) begin
      big = F1;
      sml = F2;
    end else begin
      big = F2;
      sml = F1;
    end
    sub = big[31] ^ sml[31];
    ex  = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    ey  = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mx  = {|big[30:23], big[22:0]};
    my  = {|sml[30:23], sml[22:0]};
    ax  = {mx, 3'b000};
    ay  = {my, 3'b000};
    d   = ex - ey;
    dd  = (d > 8'd27) ? 8'd27 : d;
    // Bits shifted out of the smaller operand collapse into a sticky bit.
    sh  = {ay, 27'd0} >> dd;
    yy  = {sh[53:28], sh[27] | (|sh[26:0])};
    s   = sub ? ({1'b0, ax} - {1'b0, yy}) : ({1'b0, ax} + {1'b0, yy});

    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (s[i]) found = 1'b1;
        else      lz = lz + 5'd1;
      end
    end

    lim   = ex - 8'd1;
    shamt = 8'd0;
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = {2'b00, ex} + 10'd1;
    end else begin
      shamt = ({3'b000, lz} < lim) ? {3'b000, lz} : lim;
      n     = s[26:0] << shamt;
      e     = {2'b00, ex} - {2'b00, shamt};
    end

    // Round to nearest, ties to even.
    rnd = n[2] & (n[1] | n[0] | n[3]);
    m   = {1'b0, n[26:3]} + {24'd0, rnd};
    if (m[24]) begin
      e    = e + 10'd1;
      frac = m[23:1];
    end else begin
      if (!m[23]) e = 10'd0;
      frac = m[22:0];
    end

    if (s == 28'd0)       norm = 32'h0000_0000;
    else if (e >= 10'd255) norm = {big[31], 8'hFF, 23'd0};
    else                   norm = {big[31], e[7:0], frac};

    if (nan_a || nan_b)                      F3 = 32'h7FC0_0000;
    else if (inf_a && inf_b && (F1[31] != F2[31])) F3 = 32'h7FC0_0000;
    else if (inf_a)                          F3 = F1;
    else if (inf_b)                          F3 = F2;
    else if (zero_a && zero_b)               F3 = {F1[31] & F2[31], 31'd0};
    else if (zero_a)                         F3 = F2;
    else if (zero_b)                         F3 = F1;
    else                                     F3 = norm;
  end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter: LAT=2 main instance, LAT=1 instance.
module tb_fpu_add_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  rsp_data;
  logic         busy;
  logic [1:0]   grant_id;

  logic [3:0]   l1_req_valid, l1_req_ready, l1_rsp_valid, l1_rsp_ready;
  logic [127:0] l1_req_a, l1_req_b;
  logic [31:0]  l1_rsp_data;
  logic         l1_busy;
  logic [1:0]   l1_grant_id;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpu_add_arbiter #(.N_REQ(4), .LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy), .grant_id(grant_id)
  );

  fpu_add_arbiter #(.N_REQ(4), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready),
    .req_a(l1_req_a), .req_b(l1_req_b),
    .rsp_valid(l1_rsp_valid), .rsp_data(l1_rsp_data),
    .rsp_ready(l1_rsp_ready), .busy(l1_busy), .grant_id(l1_grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grab(output int idx);
    bit seen;
    seen = 1'b0;
    idx  = -1;
    for (int c = 0; c < 30 && !seen; c++) begin
      #1;
      chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (|(req_ready & req_valid)) begin
        seen = 1'b1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
      end
      step();
    end
    chk("grab_seen", 32'(seen), 32'd1);
  endtask

  task automatic do_op(input int idx, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input string tag);
    int g;
    bit seen;
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_valid[idx] = 1'b1;
    rsp_ready = 4'hF;
    grab(g);
    req_valid[idx] = 1'b0;
    chk({tag, "_grant"}, 32'(g), 32'(idx));
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (rsp_valid[idx]) seen = 1'b1;
      else step();
    end
    chk({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    chk(tag, rsp_data, exp);
    step();
  endtask

  int g;
  bit seen;
  int rr_exp [10] = '{0, 1, 2, 3, 0, 1, 2, 0, 2, 0};
  int hs [16];
  int rs [16];
  int nh, nr;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    l1_req_valid = '0; l1_rsp_ready = '0; l1_req_a = '0; l1_req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Single request, cycle-accurate
    req_a[31:0] = 32'h3F80_0000;
    req_b[31:0] = 32'h4000_0000;
    req_valid = 4'b0001;
    rsp_ready = 4'b0001;
    #1;
    chk("c0_req_ready", 32'(req_ready), 32'h1);
    chk("c0_busy", 32'(busy), 32'h0);
    step();
    req_valid = 4'b0000;
    chk("c1_busy", 32'(busy), 32'h1);
    chk("c1_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("c1_req_ready", 32'(req_ready), 32'h0);
    step();
    chk("c2_busy", 32'(busy), 32'h1);
    chk("c2_rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    chk("c3_busy", 32'(busy), 32'h1);
    chk("c3_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("c3_rsp_data", rsp_data, 32'h4040_0000);
    step();
    chk("c4_busy", 32'(busy), 32'h0);
    chk("c4_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("c4_rsp_data_hold", rsp_data, 32'h4040_0000);
    chk("c4_grant_id", 32'(grant_id), 32'h0);

    // Operand patterns
    do_op(1, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, "nan");
    do_op(3, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, "inf");
    do_op(2, 32'h0000_0000, 32'h40A0_0000, 32'h40A0_0000, "zero");
    do_op(0, 32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, "sub");
    do_op(1, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, "cancel");
    do_op(2, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, "rne");
    do_op(3, 32'h3FC0_0000, 32'h4010_0000, 32'h4070_0000, "mix");

    // Round-robin fairness from a fresh reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'h3F80_0000;
      req_b[32*i +: 32] = 32'h3F80_0000;
    end
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (k == 6) req_valid = 4'b0101;
      grab(g);
      chk("rr_order", 32'(g), 32'(rr_exp[k]));
    end
    req_valid = 4'h0;
    repeat (5) step();

    // Response backpressure
    req_a[31:0] = 32'h4040_0000;
    req_b[31:0] = 32'hBF80_0000;
    req_valid = 4'b0001;
    rsp_ready = 4'b0000;
    grab(g);
    chk("bp_grant", 32'(g), 32'h0);
    req_valid = 4'b1110;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (|rsp_valid) seen = 1'b1;
      else step();
    end
    chk("bp_rsp_seen", 32'(seen), 32'd1);
    for (int c = 0; c < 5; c++) begin
      rsp_ready = 4'b1110;
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_data", rsp_data, 32'h4000_0000);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_busy", 32'(busy), 32'h1);
      step();
    end
    rsp_ready = 4'b0001;
    step();
    chk("bp_done_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("bp_done_busy", 32'(busy), 32'h0);
    chk("bp_next_ready", 32'(req_ready), 32'h2);
    req_valid = 4'b0000;
    rsp_ready = 4'hF;
    step();

    // Reset in the middle of EXEC
    req_a[95:64] = 32'h3F80_0000;
    req_b[95:64] = 32'h3F80_0000;
    req_valid = 4'b0100;
    grab(g);
    req_valid = 4'b0000;
    chk("mr_grant", 32'(g), 32'h2);
    chk("mr_pre_busy", 32'(busy), 32'h1);
    chk("mr_pre_grant_id", 32'(grant_id), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mr_rsp_data", rsp_data, 32'h0);
    chk("mr_grant_id", 32'(grant_id), 32'h0);
    chk("mr_req_ready", 32'(req_ready), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      chk("mr_no_rsp", 32'(rsp_valid), 32'h0);
      step();
    end
    req_valid = 4'b0101;
    #1;
    chk("mr_next_grant", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    step();

    // LAT=1 instance, back-to-back single requester
    l1_req_a[31:0] = 32'h3F80_0000;
    l1_req_b[31:0] = 32'h4000_0000;
    l1_req_valid = 4'b0001;
    l1_rsp_ready = 4'hF;
    nh = 0;
    nr = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (l1_req_ready[0] && l1_req_valid[0] && nh < 16) begin
        hs[nh] = c;
        nh++;
      end
      if (l1_rsp_valid[0] && nr < 16) begin
        if (nr == 0) chk("l1_rsp_data", l1_rsp_data, 32'h4040_0000);
        rs[nr] = c;
        nr++;
      end
      step();
    end
    l1_req_valid = 4'b0000;
    chk("l1_hs_count", 32'(nh), 32'd4);
    chk("l1_rsp_count", 32'(nr), 32'd4);
    chk("l1_latency", 32'(rs[0] - hs[0]), 32'd2);
    chk("l1_period_a", 32'(hs[1] - hs[0]), 32'd3);
    chk("l1_period_b", 32'(hs[2] - hs[1]), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
